// File: rtl/slicer_pkg.sv
// Shared types and helpers for the slicer sequencer: state and pacer
// encodings, error causes, datapath widths and the slice-target helper.
package slicer_pkg;

   localparam int DIST_W  = 17;
   localparam int SLICE_W = 5;
   localparam int PROD_W  = DIST_W + SLICE_W + 1;

   typedef logic [DIST_W-1:0] dist_t;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_REF    = 4'd1,
      S_ADV    = 4'd2,
      S_SETTLE = 4'd3,
      S_CUT    = 4'd4,
      S_CUTW   = 4'd5,
      S_RET    = 4'd6,
      S_DONE   = 4'd7,
      S_ERR    = 4'd8
   } state_t;

   // Pacer phases: PEND means a request is owed as soon as pause lifts.
   typedef enum logic [1:0] {
      P_OFF  = 2'd0,
      P_WAIT = 2'd1,
      P_GAP  = 2'd2,
      P_PEND = 2'd3
   } pacer_phase_t;

   localparam logic [1:0] ERR_RANGER = 2'd1;
   localparam logic [1:0] ERR_RANGE  = 2'd2;
   localparam logic [1:0] ERR_CUT    = 2'd3;

   typedef struct packed {
      logic  bad;
      dist_t tgt;
   } target_t;

   // Target for slice number k: ref_d - thick*k. Flags a borrow or a
   // target closer than min_dist as unusable.
   function automatic target_t calc_target(input dist_t ref_d,
                                           input logic [SLICE_W:0] k,
                                           input dist_t thick,
                                           input dist_t min_dist);
      logic [PROD_W-1:0] step;
      target_t           r;
      step  = {{(SLICE_W+1){1'b0}}, thick} * {{DIST_W{1'b0}}, k};
      r.bad = step > {{(SLICE_W+1){1'b0}}, ref_d};
      r.tgt = ref_d - step[DIST_W-1:0];
      if (r.tgt < min_dist) r.bad = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/slice_meas_pacer.sv
// Ranger pacer: issues one-cycle requests, waits for the answer with a
// timeout, retries twice, and spaces requests by a fixed idle gap.
module slice_meas_pacer
   import slicer_pkg::*;
#(
   parameter int unsigned MEAS_GAP     = 3_000_000,
   parameter int unsigned MEAS_TIMEOUT = 2_000_000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              kick,
   input  logic              hold,
   input  logic              meas_valid,
   input  logic [DIST_W-1:0] distance,
   output logic              meas_req,
   output logic              rd_valid,
   output logic [DIST_W-1:0] rd_dist,
   output logic              rd_fail
);

   localparam int unsigned LONGEST = (MEAS_GAP > MEAS_TIMEOUT) ? MEAS_GAP : MEAS_TIMEOUT;
   localparam int          TW      = $clog2(LONGEST + 1);
   localparam logic [TW-1:0] GAP_LAST = TW'(MEAS_GAP - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(MEAS_TIMEOUT - 1);

   pacer_phase_t phase;
   logic [TW-1:0] timer;
   logic [1:0]    retries;
   logic          expire;

   // Readings and the final timeout reach the sequencer in the same cycle.
   always_comb begin
      // NOTE: every combinational output is given a value first, so no path leaves it unassigned and no latch is inferred.
      rd_valid = 1'b0;
      expire   = 1'b0;
      rd_dist  = distance;
      if (run && !hold && phase == P_WAIT) begin
         rd_valid = meas_valid;
         expire   = !meas_valid && (timer == TO_LAST);
      end
      rd_fail = expire && (retries == 2'd2);
   end

   // Request/wait/gap cycle; frozen while held, restarted by kick.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase    <= P_OFF;
         timer    <= '0;
         retries  <= '0;
         meas_req <= 1'b0;
      end else begin
         meas_req <= 1'b0;
         if (kick) begin
            retries <= '0;
            timer   <= '0;
            if (hold) begin
               phase <= P_PEND;
            end else begin
               phase    <= P_WAIT;
               meas_req <= 1'b1;
            end
         end else if (!run) begin
            phase <= P_OFF;
         end else if (hold) begin
            // A reading that lands during pause is dropped and re-requested.
            if (phase == P_WAIT && meas_valid) phase <= P_PEND;
         end else begin
            case (phase)
               P_PEND: begin
                  meas_req <= 1'b1;
                  phase    <= P_WAIT;
                  timer    <= '0;
               end
               P_WAIT: begin
                  if (meas_valid) begin
                     retries <= '0;
                     phase   <= P_GAP;
                     timer   <= '0;
                  end else if (timer == TO_LAST) begin
                     if (retries == 2'd2) begin
                        phase <= P_OFF;
                     end else begin
                        retries <= retries + 2'd1;
                        phase   <= P_GAP;
                        timer   <= '0;
                     end
                  end else begin
                     timer <= timer + 1'b1;
                  end
               end
               P_GAP: begin
                  if (timer == GAP_LAST) begin
                     meas_req <= 1'b1;
                     phase    <= P_WAIT;
                     timer    <= '0;
                  end else begin
                     timer <= timer + 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: rtl/slice_sequencer.sv
// Multi-slice sequencer: references the ranger, steps the track one slice
// thickness at a time under distance feedback, cuts, then returns home.
module slice_sequencer
   import slicer_pkg::*;
#(
   parameter int unsigned THICK        = 40,
   parameter int unsigned TOL          = 4,
   parameter int unsigned STABLE_N     = 3,
   parameter int unsigned MIN_DIST     = 20,
   parameter int unsigned MEAS_GAP     = 3_000_000,
   parameter int unsigned MEAS_TIMEOUT = 2_000_000,
   parameter int unsigned CUT_TIMEOUT  = 50_000_000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               pause_i,
   input  logic [SLICE_W-1:0] slice_num_i,
   output logic               meas_req_o,
   input  logic               meas_valid_i,
   input  logic [DIST_W-1:0]  distance_i,
   output logic               move_o,
   output logic               back_o,
   output logic               cut_o,
   input  logic               cut_end_i,
   output logic               busy_o,
   output logic               finish_o,
   output logic               err_o,
   output logic [1:0]         err_code_o,
   output logic [SLICE_W-1:0] done_cnt_o,
   output logic [3:0]         state_o
);

   localparam int CW = $clog2(CUT_TIMEOUT + 1);
   localparam int SW = $clog2(STABLE_N + 1);
   localparam logic [CW-1:0]   CUT_LAST    = CW'(CUT_TIMEOUT - 1);
   localparam logic [SW-1:0]   STABLE_LAST = SW'(STABLE_N - 1);
   localparam dist_t           THICK_D     = DIST_W'(THICK);
   localparam dist_t           MIN_D       = DIST_W'(MIN_DIST);
   localparam logic [DIST_W:0] TOL_W       = (DIST_W+1)'(TOL);

   state_t             state;
   dist_t              ref_d;
   dist_t              tgt;
   logic [SLICE_W-1:0] slice_cnt;
   logic [SW-1:0]      stable;
   logic [CW-1:0]      cut_timer;

   logic               rd_valid;
   logic               rd_fail;
   dist_t              rd_dist;
   logic               measuring;
   logic               start_ok;
   logic               last_cut;
   logic               kick;
   logic               above;
   logic               below;
   logic               home;
   target_t            ref_tgt;
   target_t            next_tgt;

   // Distance comparisons, next-target arithmetic and the pacer restart.
   always_comb begin
      measuring = state inside {S_REF, S_ADV, S_SETTLE, S_RET};
      start_ok  = (state == S_IDLE || state == S_DONE) && start_i && !pause_i;
      last_cut  = (done_cnt_o + 1'b1) == slice_cnt;
      ref_tgt   = calc_target(rd_dist, (SLICE_W+1)'(1), THICK_D, MIN_D);
      next_tgt  = calc_target(ref_d, {1'b0, done_cnt_o} + (SLICE_W+1)'(2), THICK_D, MIN_D);
      above     = {1'b0, rd_dist} > {1'b0, tgt} + TOL_W;
      below     = {1'b0, rd_dist} + TOL_W < {1'b0, tgt};
      home      = {1'b0, rd_dist} + TOL_W >= {1'b0, ref_d};
      kick      = (start_ok && slice_num_i != '0) ||
                  (state == S_CUTW && cut_end_i && (last_cut || !next_tgt.bad));
   end

   slice_meas_pacer #(
      .MEAS_GAP     (MEAS_GAP),
      .MEAS_TIMEOUT (MEAS_TIMEOUT)
   ) u_pacer (
      .clk        (clk),
      .rst        (rst),
      .run        (measuring),
      .kick       (kick),
      .hold       (pause_i),
      .meas_valid (meas_valid_i),
      .distance   (distance_i),
      .meas_req   (meas_req_o),
      .rd_valid   (rd_valid),
      .rd_dist    (rd_dist),
      .rd_fail    (rd_fail)
   );

   // Moves to state s and registers every output that depends on it.
   task automatic enter(input state_t s);
      // NOTE: non-blocking throughout the sequential path, so every decision this cycle sees the pre-edge values.
      state   <= s;
      state_o <= s;
      busy_o  <= !(s inside {S_IDLE, S_DONE, S_ERR});
      move_o  <= (s == S_ADV) && !pause_i;
      back_o  <= (s == S_RET) && !pause_i;
   endtask

   task automatic fail(input logic [1:0] code);
      enter(S_ERR);
      err_o      <= 1'b1;
      err_code_o <= code;
   endtask

   // Sequencer FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         state_o    <= '0;
         busy_o     <= 1'b0;
         move_o     <= 1'b0;
         back_o     <= 1'b0;
         cut_o      <= 1'b0;
         finish_o   <= 1'b0;
         err_o      <= 1'b0;
         err_code_o <= '0;
         done_cnt_o <= '0;
         slice_cnt  <= '0;
         ref_d      <= '0;
         tgt        <= '0;
         stable     <= '0;
         cut_timer  <= '0;
      end else begin
         cut_o <= 1'b0;
         enter(state);
         case (state)
            S_IDLE, S_DONE: begin
               if (start_ok) begin
                  slice_cnt  <= slice_num_i;
                  done_cnt_o <= '0;
                  if (slice_num_i == '0) begin
                     finish_o <= 1'b1;
                     enter(S_DONE);
                  end else begin
                     finish_o <= 1'b0;
                     enter(S_REF);
                  end
               end
            end
            S_REF: begin
               if (rd_fail) begin
                  fail(ERR_RANGER);
               end else if (rd_valid) begin
                  ref_d <= rd_dist;
                  if (ref_tgt.bad) begin
                     fail(ERR_RANGE);
                  end else begin
                     tgt <= ref_tgt.tgt;
                     enter(S_ADV);
                  end
               end
            end
            S_ADV: begin
               if (rd_fail) begin
                  fail(ERR_RANGER);
               end else if (rd_valid && !above) begin
                  if (below) begin
                     fail(ERR_RANGE);
                  end else begin
                     stable <= SW'(1);
                     enter(S_SETTLE);
                  end
               end
            end
            S_SETTLE: begin
               if (rd_fail) begin
                  fail(ERR_RANGER);
               end else if (rd_valid) begin
                  if (above) begin
                     enter(S_ADV);
                  end else if (below) begin
                     fail(ERR_RANGE);
                  end else if (stable == STABLE_LAST) begin
                     enter(S_CUT);
                  end else begin
                     stable <= stable + 1'b1;
                  end
               end
            end
            S_CUT: begin
               if (!pause_i) begin
                  cut_o     <= 1'b1;
                  cut_timer <= '0;
                  enter(S_CUTW);
               end
            end
            S_CUTW: begin
               // The cut stroke is mechanical, so it completes even under pause.
               if (cut_end_i) begin
                  done_cnt_o <= done_cnt_o + 1'b1;
                  if (last_cut) begin
                     enter(S_RET);
                  end else if (next_tgt.bad) begin
                     fail(ERR_RANGE);
                  end else begin
                     tgt <= next_tgt.tgt;
                     enter(S_ADV);
                  end
               end else if (cut_timer == CUT_LAST) begin
                  fail(ERR_CUT);
               end else begin
                  cut_timer <= cut_timer + 1'b1;
               end
            end
            S_RET: begin
               if (rd_fail) begin
                  fail(ERR_RANGER);
               end else if (rd_valid && home) begin
                  finish_o <= 1'b1;
                  enter(S_DONE);
               end
            end
            S_ERR: ;
            default: enter(S_IDLE);
         endcase
      end
   end

endmodule

// File: tb/tb_slice_sequencer.sv
// Directed bench for slice_sequencer with shortened timers
// (gap 4, ranger timeout 10, cut timeout 30).
module tb_slice_sequencer;
   import slicer_pkg::*;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               start_i = 1'b0;
   logic               pause_i = 1'b0;
   logic [SLICE_W-1:0] slice_num_i = '0;
   logic               meas_valid_i = 1'b0;
   logic [DIST_W-1:0]  distance_i = '0;
   logic               cut_end_i = 1'b0;
   logic               meas_req_o, move_o, back_o, cut_o, busy_o, finish_o, err_o;
   logic [1:0]         err_code_o;
   logic [SLICE_W-1:0] done_cnt_o;
   logic [3:0]         state_o;

   int checks = 0;
   int errors = 0;
   int req_pulses = 0;
   int cut_pulses = 0;

   always #5 clk = ~clk;

   slice_sequencer #(
      .MEAS_GAP     (4),
      .MEAS_TIMEOUT (10),
      .CUT_TIMEOUT  (30)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start_i),
      .pause_i      (pause_i),
      .slice_num_i  (slice_num_i),
      .meas_req_o   (meas_req_o),
      .meas_valid_i (meas_valid_i),
      .distance_i   (distance_i),
      .move_o       (move_o),
      .back_o       (back_o),
      .cut_o        (cut_o),
      .cut_end_i    (cut_end_i),
      .busy_o       (busy_o),
      .finish_o     (finish_o),
      .err_o        (err_o),
      .err_code_o   (err_code_o),
      .done_cnt_o   (done_cnt_o),
      .state_o      (state_o)
   );

   // Pulse counters, sampled just after each active edge.
   always @(posedge clk) begin
      #1;
      if (meas_req_o) req_pulses++;
      if (cut_o) cut_pulses++;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_req();
      int n = 0;
      while (!meas_req_o && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("meas_req seen", 32'(meas_req_o), 1);
   endtask

   // Answer the next ranger request two cycles after it appears.
   task automatic respond(input int d);
      wait_req();
      repeat (2) @(negedge clk);
      meas_valid_i = 1'b1;
      distance_i   = 17'(d);
      @(negedge clk);
      meas_valid_i = 1'b0;
   endtask

   initial begin
      int snap;
      int nreq;
      int req_t [3];

      repeat (3) @(negedge clk);
      check("reset state", 32'(state_o), 32'(S_IDLE));
      check("reset outputs", 32'({meas_req_o, move_o, back_o, cut_o, busy_o, finish_o,
                                  err_o, err_code_o, done_cnt_o}), 0);
      rst = 1'b0;
      @(negedge clk);

      // Two slices from ref 400: targets 360 then 320, bounce on the second.
      slice_num_i = 5'd2;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      check("start state", 32'(state_o), 32'(S_REF));
      check("start req", 32'(meas_req_o), 1);
      check("start busy", 32'(busy_o), 1);
      respond(400);
      check("ref->adv", 32'(state_o), 32'(S_ADV));
      check("adv move", 32'(move_o), 1);
      respond(380);
      check("far stays adv", 32'(state_o), 32'(S_ADV));
      respond(362);
      check("tgt+2 settle", 32'(state_o), 32'(S_SETTLE));
      check("settle move off", 32'(move_o), 0);
      respond(361);
      check("stable 2", 32'(state_o), 32'(S_SETTLE));
      respond(360);
      check("stable 3 cut", 32'(state_o), 32'(S_CUT));
      @(negedge clk);
      check("cut pulse 1", 32'(cut_o), 1);
      check("cutw", 32'(state_o), 32'(S_CUTW));
      cut_end_i = 1'b1;
      @(negedge clk);
      cut_end_i = 1'b0;
      check("done_cnt 1", 32'(done_cnt_o), 1);
      check("cut_end -> adv", 32'(state_o), 32'(S_ADV));
      respond(322);
      check("bounce tgt+2 settle", 32'(state_o), 32'(S_SETTLE));
      respond(329);
      check("bounce tgt+9 adv", 32'(state_o), 32'(S_ADV));
      check("bounce move", 32'(move_o), 1);
      respond(321);
      check("bounce tgt+1 settle", 32'(state_o), 32'(S_SETTLE));
      respond(320);
      check("bounce tgt settle", 32'(state_o), 32'(S_SETTLE));
      respond(317);
      check("bounce tgt-3 cut", 32'(state_o), 32'(S_CUT));
      @(negedge clk);
      check("cut pulse 2", 32'(cut_o), 1);
      pause_i = 1'b1;
      @(negedge clk);
      cut_end_i = 1'b1;
      @(negedge clk);
      cut_end_i = 1'b0;
      check("paused cut_end counted", 32'(done_cnt_o), 2);
      check("paused ret state", 32'(state_o), 32'(S_RET));
      check("paused back off", 32'(back_o), 0);
      check("paused no req", 32'(meas_req_o), 0);
      pause_i = 1'b0;
      @(negedge clk);
      check("ret back on", 32'(back_o), 1);
      check("ret re-request", 32'(meas_req_o), 1);
      respond(380);
      check("ret short of home", 32'(state_o), 32'(S_RET));
      check("ret still back", 32'(back_o), 1);
      respond(396);
      check("done state", 32'(state_o), 32'(S_DONE));
      check("done finish", 32'(finish_o), 1);
      check("done back off", 32'(back_o), 0);
      check("done not busy", 32'(busy_o), 0);
      check("done count", 32'(done_cnt_o), 2);
      check("two cut pulses", 32'(cut_pulses), 2);

      // Zero slices: straight to DONE with no ranger traffic.
      snap = req_pulses;
      slice_num_i = 5'd0;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      check("zero done", 32'(state_o), 32'(S_DONE));
      check("zero finish", 32'(finish_o), 1);
      check("zero count cleared", 32'(done_cnt_o), 0);
      repeat (5) @(negedge clk);
      check("zero no req", 32'(req_pulses), 32'(snap));

      // Range error: ref 50 gives target 10, below the minimum.
      slice_num_i = 5'd1;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      check("restart ref", 32'(state_o), 32'(S_REF));
      check("restart finish clear", 32'(finish_o), 0);
      respond(50);
      check("range err state", 32'(state_o), 32'(S_ERR));
      check("range err flag", 32'(err_o), 1);
      check("range err code", 32'(err_code_o), 2);
      check("range no move", 32'(move_o), 0);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      check("start ignored in err", 32'(state_o), 32'(S_ERR));

      // Silent ranger: three requests 14 cycles apart, then ERR code 1.
      rst = 1'b1;
      @(negedge clk);
      check("rst clears err", 32'(err_o), 0);
      rst = 1'b0;
      slice_num_i = 5'd3;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      nreq = 0;
      for (int i = 0; i < 200; i++) begin
         if (meas_req_o) begin
            if (nreq < 3) req_t[nreq] = i;
            nreq++;
         end
         if (state_o == 4'(S_ERR)) break;
         @(negedge clk);
      end
      check("silent req count", 32'(nreq), 3);
      check("silent gap 1", 32'(req_t[1] - req_t[0]), 14);
      check("silent gap 2", 32'(req_t[2] - req_t[1]), 14);
      check("silent err state", 32'(state_o), 32'(S_ERR));
      check("silent err code", 32'(err_code_o), 1);
      snap = req_pulses;
      repeat (30) @(negedge clk);
      check("silent quiet after err", 32'(req_pulses), 32'(snap));

      // Pause during ADV, plus a reading discarded under pause.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      slice_num_i = 5'd1;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      respond(400);
      check("pause test adv move", 32'(move_o), 1);
      pause_i = 1'b1;
      @(negedge clk);
      check("pause move off", 32'(move_o), 0);
      check("pause state held", 32'(state_o), 32'(S_ADV));
      snap = req_pulses;
      repeat (5) @(negedge clk);
      check("pause still adv", 32'(state_o), 32'(S_ADV));
      check("pause no req", 32'(req_pulses), 32'(snap));
      pause_i = 1'b0;
      @(negedge clk);
      check("resume move", 32'(move_o), 1);
      wait_req();
      pause_i = 1'b1;
      meas_valid_i = 1'b1;
      distance_i = 17'd360;
      @(negedge clk);
      meas_valid_i = 1'b0;
      check("paused reading dropped", 32'(state_o), 32'(S_ADV));
      @(negedge clk);
      pause_i = 1'b0;
      @(negedge clk);
      check("re-request after resume", 32'(meas_req_o), 1);
      check("move after resume", 32'(move_o), 1);
      rst = 1'b1;
      @(negedge clk);
      check("rst drops move", 32'(move_o), 0);
      check("rst state idle", 32'(state_o), 32'(S_IDLE));
      rst = 1'b0;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/slice_sequencer.md
# slice_sequencer

Multi-slice sequencer for the slicer. It takes a reference distance from the ultrasonic ranger, then advances the track motor by a fixed thickness per slice, closing the loop on distance readings. At each position it fires the cut motor, and after the last slice it backs the track to the start position. It sits between the user buttons and the slice counter on one side, and the ranger and the track and cut drivers on the other.

## Interface
- THICK, 40: distance units travelled per slice.
- TOL, 4: position tolerance, in distance units.
- STABLE_N, 3: consecutive in-tolerance readings required before a cut.
- MIN_DIST, 20: smallest legal target distance.
- MEAS_GAP, 3_000_000: idle cycles between ranger requests (60 ms at 50 MHz).
- MEAS_TIMEOUT, 2_000_000: cycles to wait for `meas_valid_i` after a request.
- CUT_TIMEOUT, 50_000_000: cycles to wait for `cut_end_i`.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous reset, active-high.
- start_i  in  1  one-cycle start pulse.
- pause_i  in  1  level; freezes sequencing while high.
- slice_num_i  in  5  slices to cut; sampled on start.
- meas_req_o  out  1  one-cycle ranger trigger request.
- meas_valid_i  in  1  one-cycle pulse; `distance_i` is valid in that cycle.
- distance_i  in  17  measured distance, unsigned.
- move_o  out  1  track forward (toward blade).
- back_o  out  1  track reverse.
- cut_o  out  1  one-cycle cut request.
- cut_end_i  in  1  one-cycle pulse; cut stroke finished.
- busy_o  out  1  high in any state other than IDLE, DONE or ERR.
- finish_o  out  1  level; sequence complete.
- err_o  out  1  sticky error flag.
- err_code_o  out  2  error cause: 1 = ranger timeout, 2 = range/overshoot, 3 = cut timeout.
- done_cnt_o  out  5  slices cut so far.
- state_o  out  4  state encoding, for debug.

## Operation
States and encodings: IDLE=0, REF=1, ADV=2, SETTLE=3, CUT=4, CUTW=5, RET=6, DONE=7, ERR=8.

Start:
- In IDLE or DONE, `start_i` latches `slice_num_i`, clears `done_cnt_o` and `finish_o`, and enters REF.
- If `slice_num_i`=0, go directly to DONE.
- `start_i` is ignored in every other state.

Measurement:
- Measurement is handled by a pacer: `meas_req_o` pulses, then the pacer waits for `meas_valid_i`.
- After each result it waits MEAS_GAP cycles before the next request.
- On timeout it retries up to 2 more times; a third consecutive timeout enters ERR with code 1.
- REF, ADV, SETTLE and RET measure continuously. IDLE, CUT, CUTW, DONE and ERR do not.

Per-state behaviour:
- **REF:** the first valid reading is stored as `ref_d`. Target is computed as `tgt = ref_d − THICK·(done_cnt+1)`, in 17-bit arithmetic with a borrow check. A borrow, or `tgt` < MIN_DIST, enters ERR with code 2; otherwise go to ADV.
- **ADV:** `move_o`=1.
  - Reading `d` > `tgt`+TOL: stay in ADV.
  - Reading within ±TOL: `move_o`←0, stable count←1, go to SETTLE.
  - Reading `d` < `tgt`−TOL: ERR, code 2.
- **SETTLE:** motors off.
  - In-tolerance reading: count++. When the count reaches STABLE_N, go to CUT.
  - `d` > `tgt`+TOL: go back to ADV.
  - `d` < `tgt`−TOL: ERR, code 2.
- **CUT:** one-cycle `cut_o`, then CUTW.
- **CUTW:** wait for `cut_end_i`.
  - On `cut_end_i`: `done_cnt`++. If `done_cnt` now equals the latched count, go to RET; otherwise recompute `tgt` (same check as REF) and go to ADV.
  - CUT_TIMEOUT expiry: ERR, code 3.
- **RET:** `back_o`=1 until a reading ≥ `ref_d`−TOL, then DONE.
- **DONE:** `finish_o`=1 until the next `start_i`.
- **ERR:** all motor outputs 0. Exit only via `rst`.

Pause (`pause_i`=1):
- `move_o`, `back_o` and `meas_req_o` are forced to 0, and the state, pacer and timers hold.
- A CUTW already in progress still accepts `cut_end_i`, and its timer keeps running.
- A pending CUT does not issue `cut_o` until pause is released.

`move_o` and `back_o` are never both 1.

## Timing
- All outputs are registered.
- Reset values: every output 0; `state_o`=0; `done_cnt_o`=0.
- `start_i` in cycle n: state is REF at n+1; first `meas_req_o` at n+1.
- `meas_valid_i` in cycle n: the resulting `move_o`, `back_o` and state change are visible at n+1.
- `cut_end_i` in cycle n: `done_cnt_o` increments at n+1.
- `meas_valid_i` arriving without an outstanding request is ignored.
- `rst` mid-motion drops all motor outputs in the next cycle.
- `pause_i` and a `meas_valid_i` in the same cycle: the reading is discarded; the pacer re-requests after resume.

## Structure
- Package `slicer_pkg` holds:
  - the state enum and encodings;
  - the error-code constants;
  - `DIST_W`=17 and `SLICE_W`=5.
- Sub-module `slice_meas_pacer` covers request pulse, gap timer, timeout and retry counter. Its outputs to the sequencer are `rd_valid`, `rd_dist` and `rd_fail`.
- The top-level FSM and target arithmetic sit in `slice_sequencer`.

## Test plan
- **Two slices:** `ref_d`=400, `slice_num`=2, ranger model tracks motion. Expect targets 360 then 320, two `cut_o` pulses, `back_o` until reading ≥396, `finish_o`=1, `done_cnt_o`=2.
- **Zero slices:** `slice_num`=0. Expect DONE at start+1, no `meas_req_o`, `finish_o`=1.
- **Range error:** `ref_d`=50, THICK=40. Expect ERR with code 2 on the first target, and no `move_o`.
- **Ranger silent:** no `meas_valid_i`. Expect exactly 3 `meas_req_o` spaced by MEAS_TIMEOUT+MEAS_GAP, then ERR code 1.
- **Pause during ADV:** assert `pause_i` mid-advance. Expect `move_o`=0 next cycle, `state_o` held, and motion resumed after release; a `cut_end_i` arriving during pause in CUTW is still counted.
- **Settle bounce:** readings `tgt`+2, `tgt`+9, `tgt`+1, `tgt`, `tgt`−3. Expect SETTLE→ADV→SETTLE, then CUT after 3 in-tolerance readings.
